// File: rtl/mem_arb2_if.sv
// Bundle of both requester ports, the memory-side bus and the grant indicator.
// The arbiter takes the slave view; whatever drives requests and models the memory takes the master view.
interface mem_arb2_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        owner;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    output mem_wr, mem_rd, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  mem_wr, mem_rd, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/mem_arb2.sv
// Round-robin arbiter sharing one single-port memory between a keypad writer (A) and a display reader (B).
// Each transaction takes three cycles: a sampling cycle in IDLE, one ACCESS cycle, one DONE cycle carrying the ack.
//
// state  | meaning
// IDLE   | no transaction; requests sampled on each edge
// ACCESS | memory strobe driven for the latched winner
// DONE   | winner's ack high; requests ignored
module mem_arb2 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_arb2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_b;
  logic              win_b;
  logic              prio_b;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  always_comb begin
    state_nxt = state;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        // B wins when alone, or when both ask and A was served last
        grant_b = bus.b_req & (~bus.a_req | prio_b);
        if (bus.a_req | bus.b_req) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we_sel    = grant_b ? bus.b_we    : bus.a_we;
    addr_sel  = grant_b ? bus.b_addr  : bus.a_addr;
    wdata_sel = grant_b ? bus.b_wdata : bus.a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_b         <= 1'b0;
      prio_b        <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.owner     <= 2'b00;
      bus.a_ack     <= 1'b0;
      bus.b_ack     <= 1'b0;
      bus.a_rdata   <= '0;
      bus.b_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == ACCESS) begin
            win_b         <= grant_b;
            bus.mem_wr    <= we_sel;
            bus.mem_rd    <= ~we_sel;
            bus.mem_addr  <= addr_sel;
            bus.mem_wdata <= wdata_sel;
            bus.owner     <= grant_b ? 2'b10 : 2'b01;
          end
        end
        ACCESS: begin
          bus.mem_wr <= 1'b0;
          bus.mem_rd <= 1'b0;
          bus.a_ack  <= ~win_b;
          bus.b_ack  <= win_b;
          prio_b     <= ~win_b;
          if (bus.mem_rd) begin
            if (win_b) bus.b_rdata <= bus.mem_rdata;
            else       bus.a_rdata <= bus.mem_rdata;
          end
        end
        DONE: begin
          bus.a_ack <= 1'b0;
          bus.b_ack <= 1'b0;
          bus.owner <= 2'b00;
        end
        default: begin
          bus.mem_wr <= 1'b0;
          bus.mem_rd <= 1'b0;
          bus.a_ack  <= 1'b0;
          bus.b_ack  <= 1'b0;
          bus.owner  <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2: single-port transactions, contention, request drop, mid-access reset, address extremes.
module tb_mem_arb2;
  localparam int AW = 4;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arb2 #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] mem [16];
  assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr] : '0;
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;

  int tests = 0;
  int fails = 0;
  int ack_both = 0;
  int a_ack_cnt = 0;
  int b_ack_cnt = 0;

  always @(negedge clk) begin
    if (bus.a_ack && bus.b_ack) ack_both++;
    if (bus.a_ack) a_ack_cnt++;
    if (bus.b_ack) b_ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request from a single port; the request is withdrawn during ACCESS and the
  // inputs are scrambled to show the latched copy is what the memory sees.
  task automatic txn(input bit pb, input bit we, input logic [3:0] addr, input logic [3:0] wd,
                     input logic [3:0] exp_a_rd, input logic [3:0] exp_b_rd);
    if (pb) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
    tick;
    chk("acc_owner", 32'(bus.owner), pb ? 2 : 1);
    chk("acc_wr", 32'(bus.mem_wr), 32'(we));
    chk("acc_rd", 32'(bus.mem_rd), 32'(!we));
    chk("acc_addr", 32'(bus.mem_addr), 32'(addr));
    if (we) chk("acc_wdata", 32'(bus.mem_wdata), 32'(wd));
    chk("acc_noack", 32'(bus.a_ack | bus.b_ack), 0);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    bus.a_addr = ~addr; bus.b_addr = ~addr; bus.a_wdata = ~wd; bus.b_wdata = ~wd;
    bus.a_we = ~we; bus.b_we = ~we;
    tick;
    chk("done_owner", 32'(bus.owner), pb ? 2 : 1);
    chk("done_a_ack", 32'(bus.a_ack), pb ? 0 : 1);
    chk("done_b_ack", 32'(bus.b_ack), pb ? 1 : 0);
    chk("done_a_rdata", 32'(bus.a_rdata), 32'(exp_a_rd));
    chk("done_b_rdata", 32'(bus.b_rdata), 32'(exp_b_rd));
    chk("done_strobes", 32'({bus.mem_wr, bus.mem_rd}), 0);
    chk("done_addr_held", 32'(bus.mem_addr), 32'(addr));
    tick;
    chk("idle_owner", 32'(bus.owner), 0);
    chk("idle_acks", 32'({bus.a_ack, bus.b_ack}), 0);
  endtask

  // Both ports requesting continuously from reset-like pointer state (A first)
  int own_exp  [11] = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2};
  int aack_exp [11] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int back_exp [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int brd_exp  [11] = '{7, 7, 7, 7, 9, 9, 9, 9, 9, 9, 9};

  initial begin
    int a_snap;
    int b_snap;
    for (int i = 0; i < 16; i++) mem[i] = 4'hA;
    rst_n = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    #2;
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_strobes", 32'({bus.mem_wr, bus.mem_rd}), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_acks", 32'({bus.a_ack, bus.b_ack}), 0);
    chk("rst_rdata", 32'({bus.a_rdata, bus.b_rdata}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    chk("idle_after_rst", 32'(bus.owner), 0);

    txn(1'b0, 1'b1, 4'd3, 4'd7, 4'd0, 4'd0);
    txn(1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 4'd7);

    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd15; bus.a_wdata = 4'd9;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd15; bus.b_wdata = 4'd0;
    for (int c = 0; c < 11; c++) begin
      tick;
      chk($sformatf("cont_owner_c%0d", c + 1), 32'(bus.owner), own_exp[c]);
      chk($sformatf("cont_a_ack_c%0d", c + 1), 32'(bus.a_ack), aack_exp[c]);
      chk($sformatf("cont_b_ack_c%0d", c + 1), 32'(bus.b_ack), back_exp[c]);
      chk($sformatf("cont_b_rdata_c%0d", c + 1), 32'(bus.b_rdata), brd_exp[c]);
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    tick;
    chk("cont_end_owner", 32'(bus.owner), 0);
    chk("cont_a_rdata", 32'(bus.a_rdata), 0);

    txn(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd9);
    txn(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    txn(1'b1, 1'b0, 4'd15, 4'd0, 4'd0, 4'd9);

    a_snap = a_ack_cnt;
    txn(1'b0, 1'b0, 4'd3, 4'd0, 4'd7, 4'd9);
    tick;
    tick;
    chk("pulse_single_ack", a_ack_cnt - a_snap, 1);
    chk("pulse_idle_owner", 32'(bus.owner), 0);

    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd5; bus.a_wdata = 4'd3;
    tick;
    chk("mid_rst_wr_before", 32'(bus.mem_wr), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(bus.mem_wr), 0);
    chk("mid_rst_owner", 32'(bus.owner), 0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 0);
    chk("mid_rst_rdata", 32'(bus.a_rdata), 0);
    bus.a_req = 1'b0;
    a_snap = a_ack_cnt;
    b_snap = b_ack_cnt;
    tick;
    rst_n = 1'b1;
    repeat (4) tick;
    chk("mid_rst_no_a_ack", a_ack_cnt - a_snap, 0);
    chk("mid_rst_no_b_ack", b_ack_cnt - b_snap, 0);
    txn(1'b1, 1'b0, 4'd5, 4'd0, 4'd0, 4'hA);

    chk("acks_never_together", ack_both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width (16 locations).
REQ-002 Parameter DATA_W, default 4, memory word width (BCD digit).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 A_REQ  input  1  port A request (keypad writer); level, held until A_ACK.
REQ-006 A_WE  input  1  port A op: 1 = write, 0 = read.
REQ-007 A_ADDR  input  ADDR_W  port A address.
REQ-008 A_WDATA  input  DATA_W  port A write data.
REQ-009 A_ACK  output  1  port A completion strobe, one cycle.
REQ-010 A_RDATA  output  DATA_W  port A read data, registered.
REQ-011 B_REQ, B_WE, B_ADDR, B_WDATA, B_ACK, B_RDATA  same directions, widths, meanings as port A, for port B (display reader).
REQ-012 MEM_WR  output  1  write enable to the single-port memory.
REQ-013 MEM_RD  output  1  read enable to the memory.
REQ-014 MEM_ADDR  output  ADDR_W  memory address.
REQ-015 MEM_WDATA  output  DATA_W  memory write data.
REQ-016 MEM_RDATA  input  DATA_W  memory read data, combinational from MEM_ADDR while MEM_RD=1.
REQ-017 OWNER  output  2  current grant: 00 none, 01 A, 10 B.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; exactly one active; encoding free.
REQ-019 IDLE: no request -> stay IDLE; any REQ=1 -> latch winner's WE/ADDR/WDATA, go ACCESS next edge.
REQ-020 Arbitration round-robin: single request wins; both requesting -> port not served last wins; pointer initial = A after reset.
REQ-021 Priority pointer updates only on entry to DONE (completed transaction).
REQ-022 ACCESS (exactly 1 cycle): MEM_ADDR/MEM_WDATA = latched values; MEM_WR=WE, MEM_RD=~WE; OWNER = winner; next state DONE.
REQ-023 All MEM_* and OWNER registered outputs; MEM_WR and MEM_RD never both 1; both 0 outside ACCESS.
REQ-024 Read: MEM_RDATA captured at the edge ending ACCESS into winner's xRDATA; other port's RDATA unchanged.
REQ-025 Write: xRDATA of winner unchanged.
REQ-026 DONE (exactly 1 cycle): winner's xACK=1, OWNER held, then IDLE; requests ignored in DONE.
REQ-027 Latency: REQ high sampled at edge N -> ACCESS cycle N+1 -> ACK cycle N+2 -> IDLE N+3; max 1 transaction per 3 cycles.
REQ-028 REQ held continuously -> new transaction each 3 cycles; requester drops REQ on the edge following ACK to avoid repeat.
REQ-029 REQ deasserted during ACCESS/DONE: transaction completes and ACK still issued.
REQ-030 Changes to xWE/xADDR/xWDATA after IDLE sampling have no effect on the current transaction.
REQ-031 A_ACK and B_ACK never high together; at most one ACK per transaction.
REQ-032 ADDR full range 0..2^ADDR_W-1 passed unmodified; no wrap or clamp logic.

Reset
REQ-033 RST=0 forces immediately, without CLK: state IDLE, MEM_WR=0, MEM_RD=0, MEM_ADDR=0, MEM_WDATA=0, OWNER=00, A_ACK=B_ACK=0, A_RDATA=B_RDATA=0, pointer=A.
REQ-034 Reset during ACCESS or DONE aborts the transaction; no ACK issued after release.
REQ-035 First IDLE sampling is the first rising edge with RST=1.

Verification
REQ-036 A write only: A_REQ=1, A_WE=1, A_ADDR=3, A_WDATA=7 -> next cycle MEM_WR=1, MEM_ADDR=3, MEM_WDATA=7, OWNER=01; following cycle A_ACK=1.
REQ-037 B read: model mem[3]=7, B_REQ=1, B_WE=0, B_ADDR=3 -> MEM_RD=1 one cycle, then B_ACK=1 with B_RDATA=7; A_RDATA unchanged.
REQ-038 Contention after reset: A_REQ=B_REQ=1 held -> grants A,B,A,B; ACKs 3 cycles apart; never simultaneous.
REQ-039 Drop REQ during ACCESS: A_REQ pulsed 1 cycle -> full transaction, A_ACK=1 once, FSM returns IDLE.
REQ-040 Reset mid-ACCESS: RST=0 while MEM_WR=1 -> MEM_WR=0, OWNER=00 immediately; no ACK after RST=1.
REQ-041 Address edges: writes to addr 0 and 15 with data 0 and 9, read back via B -> B_RDATA 0 then 9.
